// File: rtl/fdiv_seq.sv
// Sequencer for x/y = x * (1/y) over the shared reciprocal ROM and multiplier.
// Optional status flags {dz, uf, busy} are built when FDIV_SEQ_FLAGS_EN is defined.
//
// state | meaning
// IDLE  | ready for operands
// INV   | waiting on the reciprocal ROM, then rebuilding the exponent of 1/y
// MUL   | x and 1/y presented to the multiplier
// DONE  | quotient valid, held until out_ready
module fdiv_seq #(
  parameter int INV_WAIT = 2,
  parameter int MUL_WAIT = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_x,
  input  logic [31:0] in_y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_q,
  output logic [22:0] finv_m,
  input  logic [31:0] finv_res,
  output logic [31:0] fmul_x,
  output logic [31:0] fmul_y,
  input  logic [31:0] fmul_res
`ifdef FDIV_SEQ_FLAGS_EN
  ,
  output logic [2:0]  flags
`endif
);

  localparam int CNT_MAX = (INV_WAIT > MUL_WAIT) ? INV_WAIT : MUL_WAIT;
  localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INV  = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   x_q, x_d;
  logic          sy_q, sy_d;
  logic [7:0]    ey_q, ey_d;
  logic [31:0]   inv_q, inv_d;
  logic [22:0]   finv_m_q, finv_m_d;
  logic [31:0]   quo_q, quo_d;
  logic signed [9:0] e;
  logic          s_in;
`ifdef FDIV_SEQ_FLAGS_EN
  logic          dz_q, dz_d;
  logic          uf_q, uf_d;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      x_q      <= '0;
      sy_q     <= 1'b0;
      ey_q     <= '0;
      inv_q    <= '0;
      finv_m_q <= '0;
      quo_q    <= '0;
`ifdef FDIV_SEQ_FLAGS_EN
      dz_q     <= 1'b0;
      uf_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      sy_q     <= sy_d;
      ey_q     <= ey_d;
      inv_q    <= inv_d;
      finv_m_q <= finv_m_d;
      quo_q    <= quo_d;
`ifdef FDIV_SEQ_FLAGS_EN
      dz_q     <= dz_d;
      uf_q     <= uf_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    sy_d     = sy_q;
    ey_d     = ey_q;
    inv_d    = inv_q;
    finv_m_d = finv_m_q;
    quo_d    = quo_q;
`ifdef FDIV_SEQ_FLAGS_EN
    dz_d     = dz_q;
    uf_d     = uf_q;
`endif
    s_in     = in_x[31] ^ in_y[31];
    // ROM returns exponent 126/127 for 1/(1.m); rebias it against y's exponent
    e = $signed({2'b00, finv_res[30:23]}) + 10'sd127 - $signed({2'b00, ey_q});

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d      = in_x;
          sy_d     = in_y[31];
          ey_d     = in_y[30:23];
          finv_m_d = in_y[22:0];
          cnt_d    = CW'(INV_WAIT - 1);
          if (in_y[30:23] == 8'h00) begin
            quo_d   = {s_in, 8'hFF, 23'h0};
            state_d = DONE;
`ifdef FDIV_SEQ_FLAGS_EN
            dz_d    = 1'b1;
`endif
          end else if (in_x[30:23] == 8'h00) begin
            quo_d   = {s_in, 31'h0};
            state_d = DONE;
          end else begin
            state_d = INV;
          end
        end
      end
      INV: begin
        if (cnt_q == '0) begin
          if (e <= 10'sd0) begin
            quo_d   = {x_q[31] ^ sy_q, 31'h0};
            state_d = DONE;
`ifdef FDIV_SEQ_FLAGS_EN
            uf_d    = 1'b1;
`endif
          end else begin
            inv_d   = {sy_q, e[7:0], finv_res[22:0]};
            cnt_d   = CW'(MUL_WAIT - 1);
            state_d = MUL;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      MUL: begin
        if (cnt_q == '0) begin
          quo_d   = fmul_res;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
`ifdef FDIV_SEQ_FLAGS_EN
          dz_d    = 1'b0;
          uf_d    = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_q     = quo_q;
  assign finv_m    = finv_m_q;
  assign fmul_x    = (state_q == MUL) ? x_q   : 32'h0;
  assign fmul_y    = (state_q == MUL) ? inv_q : 32'h0;
`ifdef FDIV_SEQ_FLAGS_EN
  assign flags     = {dz_q, uf_q, (state_q != IDLE)};
`endif

endmodule

// File: doc/fdiv_seq.md
Name: fdiv_seq

Overview:
- Multi-cycle sequencer computing x/y as x * (1/y), reusing the team's existing reciprocal unit (table-based, registered ROM read) and combinational multiplier.
- Owns the valid/ready handshake toward the issuing core and handles special cases.
- Drives the mantissa into the reciprocal unit, rebuilds the exponent of 1/y, then feeds x and 1/y to the multiplier.
- Sits between FPU issue logic and the shared finv/fmul instances.

Parameters:
- INV_WAIT, 2: cycles from driving finv_m to sampling finv_res; must be >= 1 (ROM read latency plus margin).
- MUL_WAIT, 1: cycles from driving the fmul operands to sampling fmul_res; must be >= 1.

Ports:
- clk  input  1  single clock.
- rstn  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- in_x  input  32  dividend, IEEE single.
- in_y  input  32  divisor, IEEE single.
- out_valid  output  1  quotient valid.
- out_ready  input  1  consumer accepts quotient.
- out_q  output  32  quotient.
- finv_m  output  23  mantissa to the reciprocal unit.
- finv_res  input  32  1/(1.m) from the reciprocal unit, exponent 126 or 127.
- fmul_x  output  32  multiplier operand x.
- fmul_y  output  32  multiplier operand y.
- fmul_res  input  32  multiplier result.

Behaviour:
- Reset, asynchronous, active-low:
  - State = IDLE, counter = 0.
  - in_ready = 1, out_valid = 0, out_q = 0, finv_m = 0, fmul_x = fmul_y = 0.
  - Reset mid-operation aborts the divide with no output; the first accept after rstn deasserts is legal.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, latch x and y, drive finv_m = y[22:0], and load counter = INV_WAIT-1.
  - Next state is chosen by special-case checks on the latched operands, in this priority:
    - y exponent == 0 (zero or denormal divisor): out_q = {sx^sy, 8'hFF, 23'h0}, go to DONE.
    - x exponent == 0: out_q = {sx^sy, 31'h0}, go to DONE.
    - Otherwise go to INV.
- INV:
  - finv_m is held stable; counter decrements each cycle.
  - When counter == 0, sample finv_res and compute e = finv_res[30:23] + 127 - y_exp using a signed 10-bit intermediate.
  - If e <= 0, out_q = {sx^sy, 31'h0} and go to DONE (underflow flushes to zero).
  - Else register inv = {sy, e[7:0], finv_res[22:0]}, load counter = MUL_WAIT-1, and go to MUL.
- MUL:
  - fmul_x = x, fmul_y = inv, both held stable.
  - At counter == 0, out_q = fmul_res and go to DONE.
  - Overflow and rounding are the multiplier's responsibility.
- DONE:
  - out_valid = 1; out_q is held stable while out_ready is low.
  - On out_ready, go to IDLE.
  - in_ready is 0 in DONE, so there is no same-cycle re-accept.
- Latency, accept cycle = 0:
  - Normal path: out_valid asserts at cycle INV_WAIT + MUL_WAIT + 1, which is 4 with the defaults.
  - Special cases: out_valid asserts at cycle 1.
- in_ready is 0 in INV, MUL and DONE. in_valid during those states is ignored; operands are not overwritten.
- NaN and infinite inputs are not specially handled; they follow the normal path.

Optional Feature:
- Macro FDIV_SEQ_FLAGS_EN.
- When defined:
  - Adds output flags[2:0] = {dz, uf, busy}.
  - dz: set in DONE when the divisor exponent was 0.
  - uf: set in DONE on the e <= 0 flush.
  - dz and uf are cleared on leaving DONE.
  - busy = (state != IDLE).
  - All flags reset to 0.
- When undefined: the port is absent and the logic is removed. Datapath timing is identical either way.

Test Plan:
- Reset mid-operation: assert rstn low while in INV. Required: all outputs return to reset values immediately; a subsequent 0x40000000/0x3F800000 completes with out_q 0x40000000.
- Normal divide: x = 0x40C00000, y = 0x40400000, out_ready = 1. Required: finv_m = 0x400000; inv = 0x3EAAAAAB given finv_res 0x3F2AAAAB; out_valid at cycle 4; out_q = 0x40000000 ±1 ulp.
- Divide by zero: x = 0x3F800000, y = 0x80000000. Required: out_valid at cycle 1; out_q = 0xFF800000; dz = 1 when flags enabled.
- Zero dividend and underflow:
  - x = 0x00000000, y = 0xC0000000. Required: out_q = 0x80000000 at cycle 1.
  - x = 0x3F800000, y = 0x7F400000 with finv_res 0x3F2AAAAB. Required: out_q = 0x00000000; uf = 1.
- Backpressure: hold out_ready = 0 for 5 cycles after out_valid. Required: out_q stable, in_ready = 0, and a new in_valid is not accepted; after out_ready pulses, in_ready = 1 the next cycle.
